// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if: bundles the frame receiver's control, serial and
// parallel-output handshake signals.
//   start        frame-start strobe (producer -> receiver)
//   serial_in    one data bit per cycle while the receiver is shifting
//   out_ready    consumer accepts the word when high with out_valid
//   err_clr      clears the sticky overrun flag
//   parallel_out last completed word (receiver -> consumer)
//   out_valid    parallel_out holds an unconsumed word
//   busy         receiver is mid-frame
//   overrun      sticky: a completed word was dropped
// master = link/consumer side, slave = receiver.
interface serial_frame_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  serial_in;
  logic                  out_ready;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] parallel_out;
  logic                  out_valid;
  logic                  busy;
  logic                  overrun;

  modport master (
    output start, serial_in, out_ready, err_clr,
    input  parallel_out, out_valid, busy, overrun
  );

  modport slave (
    input  start, serial_in, out_ready, err_clr,
    output parallel_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: waits for a one-cycle start strobe, deserialises the
// next DATA_WIDTH bits of serial_in and presents the word under valid/ready.
// A word completing while the previous one is still unconsumed is dropped and
// raises the sticky overrun flag.
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  serial_frame_receiver_if.slave (start, serial_in, out_ready, err_clr
//        in; parallel_out, out_valid, busy, overrun out)
// All outputs are registered.
module serial_frame_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  serial_frame_receiver_if.slave  bus
);
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d, shifted;
  logic [DATA_WIDTH-1:0] pout_q, pout_d;
  logic                  vld_q, vld_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;
  logic                  done, drop;

  // Word as it looks after shifting in the current bit; on the final bit this
  // is the completed frame, so it is loaded straight into parallel_out.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sreg_q[DATA_WIDTH-2:0], bus.serial_in};
    end else begin : g_lsb
      assign shifted = {bus.serial_in, sreg_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    pout_d  = pout_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    done    = 1'b0;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        sreg_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A consume on the completion edge frees the slot for the new word.
    if (done) begin
      if (!vld_q || bus.out_ready) begin
        pout_d = shifted;
        vld_d  = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (vld_q && bus.out_ready) begin
      vld_d = 1'b0;
    end

    // Drop beats a simultaneous clear.
    if (drop)             ovr_d = 1'b1;
    else if (bus.err_clr) ovr_d = 1'b0;

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      pout_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      pout_q  <= pout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.parallel_out = pout_q;
  assign bus.out_valid    = vld_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: drives an MSB-first and an LSB-first receiver with
// identical stimulus and compares both, every cycle, against a frame-level
// reference model (bit queue per frame, word assembled from the bit list).
module tb_serial_frame_receiver;
  logic clk;
  logic rst;

  serial_frame_receiver_if #(.DATA_WIDTH(8)) if0 ();
  serial_frame_receiver_if #(.DATA_WIDTH(8)) if1 ();

  assign if1.start     = if0.start;
  assign if1.serial_in = if0.serial_in;
  assign if1.out_ready = if0.out_ready;
  assign if1.err_clr   = if0.err_clr;

  serial_frame_receiver #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk), .rst (rst), .bus (if0)
  );
  serial_frame_receiver #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk), .rst (rst), .bus (if1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic       m_active;
  logic       bits[$];
  logic       e_vld, e_busy, e_ovr;
  logic [7:0] e_pout0, e_pout1;

  task automatic model(input logic r, input logic st, input logic sin,
                       input logic rdy, input logic clr);
    logic       done, drop;
    logic [7:0] wm, wl;
    done = 0; drop = 0; wm = '0; wl = '0;
    if (r) begin
      m_active = 0; bits.delete();
      e_vld = 0; e_busy = 0; e_ovr = 0; e_pout0 = '0; e_pout1 = '0;
    end else begin
      if (m_active) begin
        bits.push_back(sin);
        if (bits.size() == 8) begin
          done = 1; m_active = 0;
          for (int i = 0; i < 8; i++) begin
            wm[7-i] = bits[i];
            wl[i]   = bits[i];
          end
        end
      end else if (st) begin
        m_active = 1; bits.delete();
      end
      if (done) begin
        if (!e_vld || rdy) begin
          e_pout0 = wm; e_pout1 = wl; e_vld = 1;
        end else begin
          drop = 1; e_ovr = 1;
        end
      end else if (e_vld && rdy) begin
        e_vld = 0;
      end
      if (clr && !drop) e_ovr = 0;
      e_busy = m_active;
    end
  endtask

  task automatic check_all();
    chk("pout_msb", 32'(if0.parallel_out), 32'(e_pout0));
    chk("pout_lsb", 32'(if1.parallel_out), 32'(e_pout1));
    chk("valid_msb", 32'(if0.out_valid), 32'(e_vld));
    chk("valid_lsb", 32'(if1.out_valid), 32'(e_vld));
    chk("busy_msb", 32'(if0.busy), 32'(e_busy));
    chk("busy_lsb", 32'(if1.busy), 32'(e_busy));
    chk("ovr_msb", 32'(if0.overrun), 32'(e_ovr));
    chk("ovr_lsb", 32'(if1.overrun), 32'(e_ovr));
  endtask

  // One clock: apply inputs, advance model on the edge, check 1 time unit later.
  task automatic cyc(input logic r, input logic st, input logic sin,
                     input logic rdy, input logic clr);
    rst = r; if0.start = st; if0.serial_in = sin; if0.out_ready = rdy; if0.err_clr = clr;
    @(posedge clk);
    model(r, st, sin, rdy, clr);
    #1;
    check_all();
  endtask

  // Start cycle then 8 bit cycles, first bit = w[7].
  task automatic send_frame(input logic [7:0] w, input logic rdy, input logic rdy_last,
                            input logic st_in_shift);
    cyc(0, 1, 1'($urandom_range(1)), rdy, 0);
    for (int i = 0; i < 8; i++)
      cyc(0, st_in_shift, w[7-i], (i == 7) ? rdy_last : rdy, 0);
  endtask

  initial begin
    clk = 0; rst = 1;
    if0.start = 0; if0.serial_in = 0; if0.out_ready = 0; if0.err_clr = 0;
    m_active = 0; e_vld = 0; e_busy = 0; e_ovr = 0; e_pout0 = '0; e_pout1 = '0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++)
      cyc(1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(1)));
    chk("rst_pout", 32'(if0.parallel_out), 32'h0);
    chk("rst_valid", 32'(if0.out_valid), 32'h0);
    chk("rst_busy", 32'(if0.busy), 32'h0);
    chk("rst_ovr", 32'(if0.overrun), 32'h0);

    // Basic frame, 9 cycles start->valid
    send_frame(8'hA5, 0, 0, 0);
    chk("a5_msb", 32'(if0.parallel_out), 32'hA5);
    chk("a5_lsb", 32'(if1.parallel_out), 32'hA5);
    chk("a5_valid", 32'(if0.out_valid), 32'h1);
    cyc(0, 0, 0, 1, 0);
    chk("a5_consumed", 32'(if0.out_valid), 32'h0);

    // Bits 1,1,0,0,0,0,0,0
    send_frame(8'hC0, 0, 0, 0);
    chk("c0_msb", 32'(if0.parallel_out), 32'hC0);
    chk("c0_lsb", 32'(if1.parallel_out), 32'h03);
    cyc(0, 0, 0, 1, 0);

    // Overrun, then clear
    send_frame(8'h3C, 0, 0, 0);
    send_frame(8'hC3, 0, 0, 0);
    chk("ovr_keep", 32'(if0.parallel_out), 32'h3C);
    chk("ovr_set", 32'(if0.overrun), 32'h1);
    cyc(0, 0, 0, 0, 1);
    chk("ovr_clr", 32'(if0.overrun), 32'h0);
    cyc(0, 0, 0, 1, 0);

    // Consume and load on the same edge
    send_frame(8'h11, 0, 0, 0);
    send_frame(8'h22, 0, 1, 0);
    chk("simul_pout", 32'(if0.parallel_out), 32'h22);
    chk("simul_valid", 32'(if0.out_valid), 32'h1);
    chk("simul_ovr", 32'(if0.overrun), 32'h0);

    // Reset after 4 bits
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1'($urandom_range(1)), 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("midrst_valid", 32'(if0.out_valid), 32'h0);
    chk("midrst_busy", 32'(if0.busy), 32'h0);
    chk("midrst_pout", 32'(if0.parallel_out), 32'h0);
    cyc(0, 0, 0, 0, 0);

    // start held through SHIFT (incl. last bit cycle) is ignored
    send_frame(8'h5A, 1, 1, 1);
    chk("stshift_pout", 32'(if0.parallel_out), 32'h5A);
    cyc(0, 0, 0, 1, 0);
    chk("stlast_busy", 32'(if0.busy), 32'h0);

    // Back-to-back frames
    send_frame(8'h69, 1, 1, 0);
    chk("b2b_first", 32'(if0.parallel_out), 32'h69);
    send_frame(8'h96, 1, 1, 0);
    chk("b2b_second", 32'(if0.parallel_out), 32'h96);
    chk("b2b_valid", 32'(if0.out_valid), 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(199) == 0), ($urandom_range(3) == 0), 1'($urandom_range(1)),
          1'($urandom_range(1)), ($urandom_range(7) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receive-side counterpart of the team's serial data transmitter. Waits for a one-cycle `start` strobe, then deserialises the next DATA_WIDTH bits from `serial_in` into a word. The completed word is presented on `parallel_out` under a valid/ready handshake, with a sticky overrun flag. It sits at the far end of the serial link and feeds a parallel consumer (register file, FIFO, or loopback checker).

## Interface

Parameters:
- DATA_WIDTH, 8, bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in `parallel_out[DATA_WIDTH-1]`; 0: first bit lands in `parallel_out[0]`.

Ports:
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  frame-start strobe, sampled only in IDLE.
- `serial_in`  input  1  serial data, one bit per cycle while in SHIFT.
- `out_ready`  input  1  consumer accepts the word when high together with `out_valid`.
- `err_clr`  input  1  clears `overrun`.
- `parallel_out`  output  DATA_WIDTH  last completed word; held stable while `out_valid` is high.
- `out_valid`  output  1  `parallel_out` holds an unconsumed word.
- `busy`  output  1  high while in SHIFT.
- `overrun`  output  1  sticky; a completed word was dropped.

## Operation

- Reset (`rst` high at an edge): FSM to IDLE, bit counter 0, shift register 0, `parallel_out` 0, `out_valid` 0, `busy` 0, `overrun` 0. Reset wins over every other input, including mid-frame; a partial frame is discarded.
- FSM, IDLE:
  - `start` high at an edge -> SHIFT, counter cleared.
  - `serial_in` is ignored in IDLE.
- FSM, SHIFT:
  - Each edge shifts in `serial_in` and increments the counter.
  - Shift direction: MSB_FIRST=1 shifts left with the new bit at LSB; MSB_FIRST=0 shifts right with the new bit at MSB.
  - `start` is ignored while in SHIFT.
  - On the edge that captures bit DATA_WIDTH-1: return to IDLE and attempt the output load in the same edge.
- Output load at frame completion:
  - `out_valid` low, or `out_valid` and `out_ready` both high at that edge: `parallel_out` gets the completed word, `out_valid` = 1. No overrun in the simultaneous consume-and-load case.
  - `out_valid` high and `out_ready` low: the new word is dropped, `parallel_out` is unchanged, `overrun` is set.
- Handshake:
  - The word is consumed at an edge where `out_valid` and `out_ready` are both high.
  - If no frame completes on that edge, `out_valid` goes to 0 and `parallel_out` holds its old value.
  - `out_ready` with `out_valid` low has no effect.
- `overrun`:
  - Set by a drop, cleared by `err_clr`.
  - Drop and `err_clr` at the same edge: the drop wins, so `overrun` stays 1.

## Timing

- `start` sampled high at edge E0. Bits are sampled at edges E1..E(DATA_WIDTH), one bit per cycle with no gaps.
- `out_valid` and the new `parallel_out` are visible in the cycle after edge E(DATA_WIDTH). Latency is DATA_WIDTH+1 cycles from the start cycle.
- `busy` is high from the cycle after E0 through the cycle ending at E(DATA_WIDTH).
- Back-to-back frames: the earliest next `start` is sampled at E(DATA_WIDTH+1), i.e. `start` is asserted in the cycle right after the last bit cycle. A `start` asserted during the last bit cycle is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset values: hold `rst` 3 cycles with random inputs -> `parallel_out`=0x00, `out_valid`/`busy`/`overrun`=0.
- Basic frame: DATA_WIDTH=8, MSB_FIRST=1, `start` pulse, then bits 1,0,1,0,0,1,0,1 -> `parallel_out`=0xA5 and `out_valid`=1 exactly 9 cycles after the start cycle; with `out_ready`=1 for one cycle, `out_valid`=0 on the next cycle.
- LSB-first: MSB_FIRST=0, same bit sequence -> `parallel_out`=0xA5 bit-reversed = 0xA5 (palindromic pattern). Repeat with bits 1,1,0,0,0,0,0,0 -> 0x03.
- Overrun: frame 0x3C completes with `out_ready`=0, then frame 0xC3 completes with `out_ready` still 0 -> `parallel_out` stays 0x3C, `overrun`=1. Pulse `err_clr` -> `overrun`=0.
- Simultaneous consume and load: frame 0x11 pending, `out_ready`=1 exactly on the completion edge of frame 0x22 -> `parallel_out`=0x22, `out_valid` stays 1, `overrun`=0.
- Reset mid-frame / start in SHIFT: `rst` after 4 bits -> IDLE, `out_valid`=0. In a separate frame, extra `start` pulses during SHIFT -> the frame is received unchanged and back-to-back frames are both delivered.
